// File: rtl/ldpc_mem_pkg.sv
// Shared constants for the LDPC message-memory arbiters: default widths,
// requester slot assignments and the requester-index width helper.
package ldpc_mem_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;

  localparam int REQ_CNU    = 0;
  localparam int REQ_VNU    = 1;
  localparam int REQ_LOADER = 2;

  // A single requester still needs a 1-bit index field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ldpc_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module ldpc_rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_WIDTH-1:0] idx,
  output logic                any
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_back;
  logic [NUM_REQ-1:0]   w_rot;
  logic [NUM_REQ-1:0]   w_oh;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    w_dbl  = {req, req} >> ptr;
    w_rot  = w_dbl[NUM_REQ-1:0];
    w_oh   = '0;
    any    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any && w_rot[k]) begin
        w_oh[k] = 1'b1;
        any     = 1'b1;
      end
    end
    w_back = {{NUM_REQ{1'b0}}, w_oh} << ptr;
    gnt    = w_back[NUM_REQ-1:0] | w_back[2*NUM_REQ-1:NUM_REQ];
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) idx = ID_WIDTH'(i);
    end
  end

endmodule

// File: rtl/ldpc_ram_arbiter.sv
// Round-robin arbiter for one single-port sync-read message RAM.
// Define RAM_ARB_LOCK_EN to add req_lock bursts bounded by MAX_LOCK grants.
module ldpc_ram_arbiter
  import ldpc_mem_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
`ifdef RAM_ARB_LOCK_EN
  , parameter int MAX_LOCK = 16
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
`ifdef RAM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock,
`endif
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          rvalid,
  output logic [id_width(NUM_REQ)-1:0]  rid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          ram_cs,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  input  logic [DATA_WIDTH-1:0]         ram_rdata
);

  localparam int ID_WIDTH = id_width(NUM_REQ);

  logic [ID_WIDTH-1:0] r_ptr;
  logic [ID_WIDTH-1:0] r_rid;
  logic                r_rvalid;
  logic [NUM_REQ-1:0]  w_pick;
  logic [ID_WIDTH-1:0] w_idx;
  logic [ID_WIDTH-1:0] w_idx_inc;
  logic [ID_WIDTH-1:0] w_ptr_nxt;
  logic                w_found;
  logic                w_any;

  ldpc_rr_pick #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_pick (
    .req (req),
    .ptr (r_ptr),
    .gnt (w_pick),
    .idx (w_idx),
    .any (w_found)
  );

  // Grants are masked during reset so the RAM sees no access while rst_n is low.
  assign w_any     = w_found & rst_n;
  assign gnt       = rst_n ? w_pick : '0;
  assign ram_cs    = w_any;
  assign ram_we    = w_any & req_we[w_idx];
  assign ram_addr  = req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign ram_wdata = req_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_idx_inc = (w_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;

  assign rvalid = r_rvalid;
  assign rid    = r_rid;
  assign rdata  = ram_rdata;

`ifdef RAM_ARB_LOCK_EN
  localparam int LOCK_W = id_width(MAX_LOCK + 1);

  logic [LOCK_W-1:0] r_lock_cnt;
  logic [LOCK_W-1:0] w_cnt_nxt;
  logic              w_locked;

  assign w_locked = w_any & req_lock[w_idx];

  // Parking ptr on the holder keeps its grant; the last allowed locked grant
  // moves ptr past it so one arbitration round runs before it can lock again.
  always_comb begin
    w_ptr_nxt = w_idx_inc;
    w_cnt_nxt = '0;
    if (w_locked && (r_lock_cnt < LOCK_W'(MAX_LOCK - 1))) begin
      w_ptr_nxt = w_idx;
      w_cnt_nxt = r_lock_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lock_cnt <= '0;
    else        r_lock_cnt <= w_cnt_nxt;
  end
`else
  assign w_ptr_nxt = w_idx_inc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_rvalid <= 1'b0;
      r_rid    <= '0;
    end else begin
      r_rvalid <= w_any & ~req_we[w_idx];
      if (w_any) begin
        r_rid <= w_idx;
        r_ptr <= w_ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ldpc_ram_arbiter.sv
// Directed bench for ldpc_ram_arbiter with a behavioural sync-read RAM.
module tb_ldpc_ram_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  req, req_we, gnt;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic          rvalid, ram_cs, ram_we;
  logic [1:0]    rid;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
`ifdef RAM_ARB_LOCK_EN
  logic [N-1:0]  req_lock;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ldpc_ram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
`ifdef RAM_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rid       (rid),
    .rdata     (rdata),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Unwritten locations read back as addr ^ 0x5A.
  logic [DW-1:0] mem [256];
  bit   [255:0]  wr_ok;
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        mem[ram_addr]   <= ram_wdata;
        wr_ok[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= wr_ok[ram_addr] ? mem[ram_addr] : (ram_addr ^ 8'h5A);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [7:0] a, input logic [7:0] d);
    req[i]              = 1'b1;
    req_we[i]           = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    req = '0; req_we = '0;
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
`ifdef RAM_ARB_LOCK_EN
    req_lock = '0;
`endif
    #1 rst_n = 1'b0;
    req = 4'b1111;
    #1;
    n_chk++; if (gnt !== 4'b0000) $display("FAIL rst_gnt: got %b want 0000", gnt); else n_pass++;
    n_chk++; if (ram_cs !== 1'b0) $display("FAIL rst_cs: got %b want 0", ram_cs); else n_pass++;
    n_chk++; if (rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", rvalid); else n_pass++;
    n_chk++; if (rid !== 2'd0) $display("FAIL rst_rid: got %0d want 0", rid); else n_pass++;
    req = '0;
    #20;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    cyc();
    set_req(1, 1'b1, 8'h10, 8'hA5);
    #1;
    n_chk++; if (gnt !== 4'b0010) $display("FAIL wr_gnt: got %b want 0010", gnt); else n_pass++;
    n_chk++; if (ram_cs !== 1'b1) $display("FAIL wr_cs: got %b want 1", ram_cs); else n_pass++;
    n_chk++; if (ram_we !== 1'b1) $display("FAIL wr_we: got %b want 1", ram_we); else n_pass++;
    n_chk++; if (ram_addr !== 8'h10) $display("FAIL wr_addr: got %h want 10", ram_addr); else n_pass++;
    n_chk++; if (ram_wdata !== 8'hA5) $display("FAIL wr_data: got %h want a5", ram_wdata); else n_pass++;
    cyc();
    req_we[1] = 1'b0;
    #1;
    n_chk++; if (gnt !== 4'b0010) $display("FAIL rd_gnt: got %b want 0010", gnt); else n_pass++;
    n_chk++; if (ram_we !== 1'b0) $display("FAIL rd_we: got %b want 0", ram_we); else n_pass++;
    n_chk++; if (rvalid !== 1'b0) $display("FAIL wr_no_rvalid: got %b want 0", rvalid); else n_pass++;
    cyc();
    req = '0;
    #1;
    n_chk++; if (rvalid !== 1'b1) $display("FAIL rd_rvalid: got %b want 1", rvalid); else n_pass++;
    n_chk++; if (rid !== 2'd1) $display("FAIL rd_rid: got %0d want 1", rid); else n_pass++;
    n_chk++; if (rdata !== 8'hA5) $display("FAIL rd_data: got %h want a5", rdata); else n_pass++;
  endtask

  task automatic test_contention();
    logic [3:0] eg;
    logic [1:0] er;
    logic [7:0] ed;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(8'h20 + i), 8'h00);
    for (int k = 0; k < 8; k++) begin
      #1;
      eg = 4'(1 << (k % 4));
      n_chk++; if (gnt !== eg) $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, eg); else n_pass++;
      if (k > 0) begin
        er = 2'((k - 1) % 4);
        ed = 8'(8'h20 + er) ^ 8'h5A;
        n_chk++; if (rvalid !== 1'b1) $display("FAIL rr_rvalid[%0d]: got %b want 1", k, rvalid); else n_pass++;
        n_chk++; if (rid !== er) $display("FAIL rr_rid[%0d]: got %0d want %0d", k, rid, er); else n_pass++;
        n_chk++; if (rdata !== ed) $display("FAIL rr_rdata[%0d]: got %h want %h", k, rdata, ed); else n_pass++;
      end
      cyc();
    end
    req = '0;
    #1;
    n_chk++; if (rid !== 2'd3) $display("FAIL rr_last_rid: got %0d want 3", rid); else n_pass++;
  endtask

  task automatic test_wrap();
    set_req(2, 1'b0, 8'h40, 8'h00);
    #1;
    n_chk++; if (gnt !== 4'b0100) $display("FAIL wrap_g2: got %b want 0100", gnt); else n_pass++;
    cyc();
    req = '0;
    set_req(0, 1'b0, 8'h30, 8'h00);
    set_req(3, 1'b0, 8'h33, 8'h00);
    #1;
    n_chk++; if (gnt !== 4'b1000) $display("FAIL wrap_g3: got %b want 1000", gnt); else n_pass++;
    n_chk++; if (rid !== 2'd2) $display("FAIL wrap_rid2: got %0d want 2", rid); else n_pass++;
    cyc();
    #1;
    n_chk++; if (gnt !== 4'b0001) $display("FAIL wrap_g0: got %b want 0001", gnt); else n_pass++;
    n_chk++; if (rid !== 2'd3) $display("FAIL wrap_rid3: got %0d want 3", rid); else n_pass++;
    cyc();
  endtask

  task automatic test_idle();
    req = '0;
    #1;
    n_chk++; if (gnt !== 4'b0000) $display("FAIL idle_gnt: got %b want 0000", gnt); else n_pass++;
    n_chk++; if (ram_cs !== 1'b0) $display("FAIL idle_cs: got %b want 0", ram_cs); else n_pass++;
    n_chk++; if (ram_we !== 1'b0) $display("FAIL idle_we: got %b want 0", ram_we); else n_pass++;
    n_chk++; if (rid !== 2'd0) $display("FAIL idle_prev_rid: got %0d want 0", rid); else n_pass++;
    cyc();
    n_chk++; if (rvalid !== 1'b0) $display("FAIL idle_rvalid: got %b want 0", rvalid); else n_pass++;
    cyc();
    set_req(0, 1'b0, 8'h01, 8'h00);
    set_req(1, 1'b0, 8'h02, 8'h00);
    #1;
    n_chk++; if (gnt !== 4'b0010) $display("FAIL idle_ptr_hold: got %b want 0010", gnt); else n_pass++;
    cyc();
    req = '0;
  endtask

  task automatic test_reset_mid();
    set_req(1, 1'b0, 8'h05, 8'h00);
    #1;
    n_chk++; if (gnt !== 4'b0010) $display("FAIL rm_gnt: got %b want 0010", gnt); else n_pass++;
    cyc();
    n_chk++; if (rvalid !== 1'b1) $display("FAIL rm_pre_rvalid: got %b want 1", rvalid); else n_pass++;
    req = 4'b0100;
    rst_n = 1'b0;
    #1;
    n_chk++; if (rvalid !== 1'b0) $display("FAIL rm_rvalid: got %b want 0", rvalid); else n_pass++;
    n_chk++; if (gnt !== 4'b0000) $display("FAIL rm_gnt_low: got %b want 0000", gnt); else n_pass++;
    n_chk++; if (ram_cs !== 1'b0) $display("FAIL rm_cs_low: got %b want 0", ram_cs); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0101;
    #1;
    n_chk++; if (gnt !== 4'b0001) $display("FAIL rm_ptr0: got %b want 0001", gnt); else n_pass++;
    req = 4'b0100;
    #1;
    n_chk++; if (gnt !== 4'b0100) $display("FAIL rm_g2: got %b want 0100", gnt); else n_pass++;
    req = '0;
  endtask

`ifdef RAM_ARB_LOCK_EN
  task automatic test_lock();
    logic [3:0] eg;
    do_reset();
    req_lock = 4'b1000;
    set_req(3, 1'b0, 8'h03, 8'h00);
    #1;
    n_chk++; if (gnt !== 4'b1000) $display("FAIL lock_first: got %b want 1000", gnt); else n_pass++;
    cyc();
    set_req(0, 1'b0, 8'h00, 8'h00);
    for (int k = 2; k <= 18; k++) begin
      #1;
      eg = (k == 17) ? 4'b0001 : 4'b1000;
      n_chk++; if (gnt !== eg) $display("FAIL lock_gnt[%0d]: got %b want %b", k, gnt, eg); else n_pass++;
      cyc();
    end
    req = '0;
    req_lock = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_wrap();
    test_idle();
    test_reset_mid();
`ifdef RAM_ARB_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
